// File: rtl/math_pkg.sv
// math_pkg: shared types, constants and helpers for the shared-adder scheduler
// Contents: clog2, saturation limits max_pos/max_neg, tag_t {valid, id[, a_msb, b_msb]}.
// MATH_ADD_SCHED_SAT_EN adds the operand sign bits to tag_t.
package math_pkg;
  localparam int ID_W_MAX = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] max_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction
  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
`ifdef MATH_ADD_SCHED_SAT_EN
    logic                a_msb;
    logic                b_msb;
`endif
  } tag_t;
endpackage

// File: rtl/math_add_fab.sv
// math_add_fab: pipelined adder, one WIDTH/(LATENCY+1) slice added per stage with carry forwarded
// Ports: clk, rst (async, active-high), ena (advances every stage), a, b, dout (a+b after LATENCY enabled edges).
module math_add_fab #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] dout
);
  localparam int S  = LATENCY + 1;
  localparam int SW = WIDTH / S;
  logic [WIDTH-1:0] a_p [S];
  logic [WIDTH-1:0] b_p [S];
  logic [WIDTH-1:0] s_p [S];
  logic             c_p [S];
  logic [WIDTH-1:0] s_n [S];
  logic             c_n [S];
  assign a_p[0] = a;
  assign b_p[0] = b;
  assign s_p[0] = '0;
  assign c_p[0] = 1'b0;
  // slices above j are still zero in s_p[j], so OR-ing in the new slice is a merge
  for (genvar j = 0; j < S; j++) begin : g_slice
    logic [SW:0] t;
    assign t = {1'b0, a_p[j][j*SW +: SW]} + {1'b0, b_p[j][j*SW +: SW]} + {{SW{1'b0}}, c_p[j]};
    assign s_n[j] = s_p[j] | (WIDTH'(t[SW-1:0]) << (j*SW));
    assign c_n[j] = t[SW];
  end
  for (genvar j = 0; j < LATENCY; j++) begin : g_stage
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             c_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (ena) begin
        a_q <= a_p[j];
        b_q <= b_p[j];
        s_q <= s_n[j];
        c_q <= c_n[j];
      end
    assign a_p[j+1] = a_q;
    assign b_p[j+1] = b_q;
    assign s_p[j+1] = s_q;
    assign c_p[j+1] = c_q;
  end
  assign dout = s_n[LATENCY];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant searched upward from pointer+1, pointer moves on accept
// Ports: clk, rst_n (async, active-low), advance, req[NUM_REQ], grant (one-hot or zero), grant_id.
module rr_arbiter import math_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;
  int             idx;
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
    ptr_d = (found && advance) ? grant_id : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= IDW'(NUM_REQ - 1);
    else ptr_q <= ptr_d;
endmodule

// File: rtl/shift_reg.sv
// shift_reg: enabled delay line with async active-high reset and all stages exposed
// Ports: clk, rst (async, active-high), ena, din[W], dout[W] (din delayed DEPTH enabled cycles),
// taps (every stage, stage 0 = newest). DEPTH=0 is a plain wire.
module shift_reg #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ena,
  input  logic [W-1:0]                          din,
  output logic [W-1:0]                          dout,
  output logic [(DEPTH > 0 ? DEPTH : 1)*W-1:0]  taps
);
  if (DEPTH == 0) begin : g_wire
    assign dout = din;
    assign taps = '0;
  end else begin : g_regs
    logic [DEPTH*W-1:0] sr_q;
    logic [DEPTH*W-1:0] sr_d;
    always_comb sr_d = ena ? ((sr_q << W) | (DEPTH*W)'(din)) : sr_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) sr_q <= '0;
      else sr_q <= sr_d;
    assign dout = sr_q[DEPTH*W-1 -: W];
    assign taps = sr_q;
  end
endmodule

// File: rtl/math_add_sched.sv
// math_add_sched: round-robin scheduler sharing one pipelined adder between NUM_REQ requesters
// Ports: clk, rst (async, active-low), ena (low freezes all state),
// req_valid/req_ready/req_a/req_b (per-requester operands, slice i*WIDTH),
// rsp_valid/rsp_ready/rsp_id/rsp_sum (registered result), busy (tag in flight or rsp_valid).
// MATH_ADD_SCHED_SAT_EN: saturate signed overflow instead of wrapping.
module math_add_sched import math_pkg::*; #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1,
  parameter int NUM_REQ = 4,
  parameter int IDW     = clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     busy
);
  localparam int TW = $bits(tag_t);
  logic                                  advance;
  logic [NUM_REQ-1:0]                    grant;
  logic [IDW-1:0]                        grant_id;
  logic [WIDTH-1:0]                      add_a, add_b, add_sum, sum_res;
  tag_t                                  tag_in, tag_out;
  logic [(LATENCY > 0 ? LATENCY : 1)*TW-1:0] taps;
  logic                                  in_flight;
  logic                                  rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]                        rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]                      rsp_sum_q, rsp_sum_d;
  assign advance = ena & (~rsp_valid_q | rsp_ready);
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .rst_n    (rst),
    .advance  (advance),
    .req      (req_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );
  // without a grant the adder sees zeros and the tag is a bubble
  always_comb begin
    req_ready    = grant & {NUM_REQ{advance}};
    add_a        = |grant ? req_a[grant_id*WIDTH +: WIDTH] : '0;
    add_b        = |grant ? req_b[grant_id*WIDTH +: WIDTH] : '0;
    tag_in       = '0;
    tag_in.valid = |(req_valid & req_ready);
    tag_in.id    = ID_W_MAX'(grant_id);
`ifdef MATH_ADD_SCHED_SAT_EN
    tag_in.a_msb = add_a[WIDTH-1];
    tag_in.b_msb = add_b[WIDTH-1];
`endif
  end
  math_add_fab #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_fab (
    .clk  (clk),
    .rst  (~rst),
    .ena  (advance),
    .a    (add_a),
    .b    (add_b),
    .dout (add_sum)
  );
  shift_reg #(.W(TW), .DEPTH(LATENCY)) u_tag (
    .clk  (clk),
    .rst  (~rst),
    .ena  (advance),
    .din  (tag_in),
    .dout (tag_out),
    .taps (taps)
  );
  // the valid bit is the MSB of each packed tag stage
  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < LATENCY; i++) in_flight = in_flight | taps[i*TW + TW - 1];
  end
`ifdef MATH_ADD_SCHED_SAT_EN
  localparam logic [63:0] MAX_POS = max_pos(WIDTH);
  localparam logic [63:0] MAX_NEG = max_neg(WIDTH);
  logic ovf;
  assign ovf     = (tag_out.a_msb == tag_out.b_msb) && (add_sum[WIDTH-1] != tag_out.a_msb);
  assign sum_res = ovf ? (tag_out.a_msb ? MAX_NEG[WIDTH-1:0] : MAX_POS[WIDTH-1:0]) : add_sum;
`else
  assign sum_res = add_sum;
`endif
  always_comb begin
    rsp_valid_d = advance ? tag_out.valid : rsp_valid_q;
    rsp_id_d    = (advance && tag_out.valid) ? IDW'(tag_out.id) : rsp_id_q;
    rsp_sum_d   = (advance && tag_out.valid) ? sum_res : rsp_sum_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = rsp_valid_q | in_flight;
endmodule

// File: tb/tb_math_add_sched.sv
// tb_math_add_sched: directed self-checking bench for math_add_sched (WIDTH=16, LATENCY=1, NUM_REQ=4)
module tb_math_add_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        rsp_ready = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic        rsp_valid, busy;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_sum;
  int errors = 0;
  int checks = 0;
  logic [15:0] ovf_pos_exp, ovf_neg_exp;
  always #5 clk = ~clk;
  math_add_sched #(.WIDTH(16), .LATENCY(1), .NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic single(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] sum, input string tag);
    @(negedge clk);
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    #1 chk({tag, "_ready"}, req_ready, 32'd1 << i);
    @(negedge clk);
    chk({tag, "_busy_flight"}, busy, 1);
    chk({tag, "_valid_early"}, rsp_valid, 0);
    req_valid = '0;
    @(negedge clk);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, i);
    chk({tag, "_sum"}, rsp_sum, sum);
    chk({tag, "_busy_out"}, busy, 1);
    @(negedge clk);
    chk({tag, "_valid_drain"}, rsp_valid, 0);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask
  initial begin
`ifdef MATH_ADD_SCHED_SAT_EN
    ovf_pos_exp = 16'h7FFF;
    ovf_neg_exp = 16'h8000;
`else
    ovf_pos_exp = 16'h8000;
    ovf_neg_exp = 16'h7FFF;
`endif
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    single(0, 16'h0003, 16'h0004, 16'h0007, "single");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = 16'(i);
      req_b[i*16 +: 16] = 16'h0010;
    end
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i < 6) chk("rr_ready", req_ready, 32'd1 << (i % 4));
      chk("rr_valid", rsp_valid, (i >= 2 && i <= 6));
      if (i >= 2 && i <= 6) begin
        chk("rr_id", rsp_id, (i - 2) % 4);
        chk("rr_sum", rsp_sum, 16'h0010 + 16'((i - 2) % 4));
      end
      if (i == 5) req_valid = '0;
      @(negedge clk);
    end
    req_a[16 +: 16] = 16'h0100;
    req_b[16 +: 16] = 16'h0023;
    req_a[32 +: 16] = 16'h0200;
    req_b[32 +: 16] = 16'h0045;
    req_valid = 4'b0110;
    #1 chk("bp_ready0", req_ready, 4'b0010);
    @(negedge clk);
    chk("bp_ready1", req_ready, 4'b0100);
    @(negedge clk);
    chk("bp_valid0", rsp_valid, 1);
    chk("bp_id0", rsp_id, 1);
    chk("bp_sum0", rsp_sum, 16'h0123);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[16 +: 16] = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_ready", req_ready, 0);
      chk("bp_stall_valid", rsp_valid, 1);
      chk("bp_stall_id", rsp_id, 1);
      chk("bp_stall_sum", rsp_sum, 16'h0123);
      chk("bp_stall_busy", busy, 1);
      @(negedge clk);
    end
    chk("bp_hold_sum", rsp_sum, 16'h0123);
    rsp_ready = 1'b1;
    #1 chk("bp_resume_ready", req_ready, 4'b0010);
    @(negedge clk);
    chk("bp_id1", rsp_id, 2);
    chk("bp_sum1", rsp_sum, 16'h0245);
    req_valid = '0;
    @(negedge clk);
    chk("bp_valid2", rsp_valid, 1);
    chk("bp_id2", rsp_id, 1);
    chk("bp_sum2", rsp_sum, 16'h0323);
    @(negedge clk);
    chk("bp_drain", rsp_valid, 0);
    single(0, 16'h00FF, 16'h0001, 16'h0100, "carry_lo");
    single(0, 16'hFFFF, 16'h0001, 16'h0000, "carry_wrap");
    single(0, 16'h7FFF, 16'h0001, ovf_pos_exp, "ovf_pos");
    single(0, 16'h8000, 16'hFFFF, ovf_neg_exp, "ovf_neg");
    @(negedge clk);
    req_valid = 4'b1100;
    #1 chk("mid_ready0", req_ready, 4'b0100);
    @(negedge clk);
    chk("mid_ready1", req_ready, 4'b1000);
    @(negedge clk);
    chk("mid_valid", rsp_valid, 1);
    chk("mid_id", rsp_id, 2);
    chk("mid_busy", busy, 1);
    req_valid = '0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_id", rsp_id, 0);
    chk("arst_sum", rsp_sum, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    req_valid = 4'hF;
    #1 chk("post_rst_grant", req_ready, 4'b0001);
    ena = 1'b0;
    #1 chk("ena_low_ready", req_ready, 0);
    req_valid = '0;
    ena = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
